// File: rtl/stream_demux_1ton.sv
// stream_demux_1ton: registered 1-to-N valid/ready demux with unicast steering and all-or-nothing broadcast.
// Define DEMUX_ERR_CNT_EN to add the saturating err_cnt port counting dropped out-of-range beats.
module stream_demux_1ton #(
    parameter int WIDTH = 8,
    parameter int CHANNELS = 4,
    parameter int ERR_CNT_W = 8,
    localparam int SEL_W = CHANNELS > 2 ? $clog2(CHANNELS) : 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    input  logic [SEL_W-1:0]           in_sel,
    input  logic                       in_bcast,
    output logic [CHANNELS-1:0]        out_valid,
    input  logic [CHANNELS-1:0]        out_ready,
    output logic [CHANNELS*WIDTH-1:0]  out_data,
    output logic                       sel_err
`ifdef DEMUX_ERR_CNT_EN
    ,
    output logic [ERR_CNT_W-1:0]       err_cnt
`endif
);
    localparam logic [SEL_W:0] NCH = (SEL_W + 1)'(CHANNELS);
    logic [CHANNELS-1:0] can_acc;
    logic [CHANNELS-1:0] sel_hot;
    logic [CHANNELS-1:0] load;
    logic                sel_ok;
    logic                acc;
    logic                drop;
    assign can_acc = ~out_valid | out_ready;
    assign sel_ok  = {1'b0, in_sel} < NCH;
    assign sel_hot = sel_ok ? CHANNELS'(1) << in_sel : '0;
    // out-of-range unicast is always accepted so the producer never deadlocks on it
    assign in_ready = rst_n && (in_bcast ? &can_acc : !sel_ok || |(sel_hot & can_acc));
    assign acc  = in_valid && in_ready;
    assign drop = acc && !in_bcast && !sel_ok;
    assign load = !acc ? '0 : in_bcast ? '1 : sel_hot;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= '0;
            out_data  <= '0;
            sel_err   <= 1'b0;
        end else begin
            out_valid <= load | (out_valid & ~out_ready);
            sel_err   <= drop;
            for (int i = 0; i < CHANNELS; i++)
                if (load[i]) out_data[i*WIDTH +: WIDTH] <= in_data;
        end
    end
`ifdef DEMUX_ERR_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_cnt <= '0;
        else if (drop && !(&err_cnt)) err_cnt <= err_cnt + 1'b1;
    end
`else
    logic unused_err_cnt_w;
    assign unused_err_cnt_w = |ERR_CNT_W;
`endif
endmodule

// File: doc/stream_demux_1ton.md
Name: stream_demux_1ton

Overview:
- Registered, parametrised 1-to-N stream demultiplexer with valid/ready handshakes. It is the sequential successor to the combinational 1-to-4 demux.
- Each input beat is steered to one output channel chosen by in_sel, or copied to all channels in broadcast mode.
- Each channel has a one-entry output register, so the block sits between a single producer and N independent consumers with back-pressure.

Parameters:
WIDTH, 8, data width per beat.
CHANNELS, 4, number of output channels (2..16).
ERR_CNT_W, 8, width of the error counter (used only with DEMUX_ERR_CNT_EN).
(Derived localparam SEL_W = clog2(CHANNELS), minimum 1; not overridable.)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  input beat valid
in_ready  out  1  input beat accepted when in_valid && in_ready
in_data  in  WIDTH  input payload
in_sel  in  SEL_W  destination channel index
in_bcast  in  1  1 = deliver the beat to all channels; in_sel ignored
out_valid  out  CHANNELS  per-channel valid; bit i = channel i
out_ready  in  CHANNELS  per-channel consumer ready
out_data  out  CHANNELS*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
sel_err  out  1  one-cycle pulse: an out-of-range unicast beat was dropped

Behaviour:
- Per channel i: full flag v[i] and data register d[i]. out_valid[i]=v[i]; out_data slice i = d[i]. Outputs are driven from registers only.
- can_acc[i] = !v[i] || out_ready[i].
- Unicast (in_bcast=0, in_sel<CHANNELS): in_ready = can_acc[in_sel].
  - On accept: d[in_sel]<=in_data and v[in_sel]<=1.
  - Latency: out_valid rises on the edge after acceptance.
- Broadcast (in_bcast=1): in_ready = AND of all can_acc[i].
  - On accept: every d[i]<=in_data and every v[i]<=1 in the same cycle. A broadcast is never partially delivered.
- Out-of-range unicast (in_sel>=CHANNELS; possible only when CHANNELS is not a power of 2): in_ready=1 and the beat is dropped. No channel changes. sel_err=1 on the following cycle only.
- Drain: v[i]&&out_ready[i] with no load to channel i clears v[i]. d[i] keeps its last value and is not zeroed.
- Simultaneous drain and load on the same channel: v[i] stays 1 and d[i] takes the new beat. Full throughput is one beat per cycle per channel.
- Channels drain independently. A stalled channel blocks only unicast beats addressed to it and all broadcasts.
- in_ready has no combinational dependency on in_valid or in_data. It depends on in_sel, in_bcast, v, out_ready and rst_n.
- Producer rule: in_data, in_sel and in_bcast stay stable while in_valid=1 and the beat is not accepted.
- Reset (rst_n low, asynchronous assert, synchronous-safe deassert):
  - v=0, d=0, sel_err=0, counter=0, in_ready forced 0.
  - Reset mid-operation discards all buffered beats.
  - The first acceptance is possible on the first rising edge after rst_n goes high.

Optional Feature:
- Macro DEMUX_ERR_CNT_EN.
- Defined: adds output port err_cnt [ERR_CNT_W-1:0]. It increments by 1 each cycle in which an out-of-range beat is dropped, saturates at all-ones and is cleared only by reset.
- Undefined: err_cnt port and counter are absent. sel_err behaviour is unchanged.

Test Plan:
- WIDTH=8, CHANNELS=4, all out_ready=1: send 0xA5 to sel 0,1,2,3 on consecutive cycles -> out_valid=0001,0010,0100,1000 one cycle after each accept; matching slice=0xA5; in_ready stays 1.
- out_ready[2]=0: send 0x11 to sel 2, then 0x22 to sel 2 -> first accepted, v[2]=1; in_ready=0 for the second beat. Raise out_ready[2] -> 0x11 drains and 0x22 loads in the same cycle; out_valid[2] stays 1 and slice 2 becomes 0x22.
- Broadcast 0x5A with out_ready=1011 and v[2]=1 -> in_ready=0 and no channel loads. Set out_ready=1111 -> accepted; out_valid=1111, all slices 0x5A.
- CHANNELS=3, in_sel=3, in_data=0xFF -> in_ready=1, out_valid unchanged, sel_err pulses 1 for exactly one cycle. With DEMUX_ERR_CNT_EN, err_cnt=1; after 300 such beats with ERR_CNT_W=8, err_cnt=255.
- Load channels 0 and 1 with out_ready=0, then pulse rst_n low mid-cycle -> out_valid=0000, all slices 0, in_ready=0 immediately. After release, 0x33 to sel 1 -> out_valid=0010 next cycle.
- Random sel, bcast and out_ready for 2000 cycles against a scoreboard model -> no lost, duplicated or reordered beats per channel, and no partial broadcasts.
